// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel delay timer: FSM state codes,
// the default prescale ratio and a width helper for the prescaler.
package timer_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    localparam int DEFAULT_TICK_DIV = 100_000_000;

    // Like $clog2, but never below 1, so a divide-by-one prescaler still has a bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: an IDLE/RUN/EXPIRED FSM, a TICK_DIV prescaler and a tick
// counter that counts up to the delay latched when the channel starts.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             periodic,
    input  logic [CNT_W-1:0] delay,
    output logic             done,
    output logic             expire,
    output logic             busy
);

    localparam int               PRE_W   = clog2_min1(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] lat_delay;
    logic [CNT_W-1:0] target;
    logic             lat_periodic;
    logic             tick;
    logic             hit;

    // A periodic zero delay reloads as if it were one tick; a one-shot zero
    // delay expires on the first unpaused RUN edge regardless of the prescaler.
    always_comb begin
        tick     = (pre == PRE_MAX);
        pre_next = tick ? '0 : pre + PRE_W'(1);
        cnt_next = tick ? cnt + CNT_ONE : cnt;
        target   = (lat_periodic && lat_delay == '0) ? CNT_ONE : lat_delay;
        hit      = (!lat_periodic && lat_delay == '0) || (cnt_next == target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pre          <= '0;
            cnt          <= '0;
            lat_delay    <= '0;
            lat_periodic <= 1'b0;
            done         <= 1'b0;
            expire       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            expire <= 1'b0;
            case (state)
                IDLE: begin
                    pre <= '0;
                    cnt <= '0;
                    if (start) begin
                        state        <= RUN;
                        lat_delay    <= delay;
                        lat_periodic <= periodic;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state <= IDLE;
                        pre   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        if (hit) begin
                            expire <= 1'b1;
                            pre    <= '0;
                            cnt    <= '0;
                            if (!lat_periodic) begin
                                state <= EXPIRED;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            pre <= pre_next;
                            cnt <= cnt_next;
                        end
                    end
                end
                EXPIRED: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pre   <= '0;
                    cnt   <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_delay_timer.sv
// N_CH independent delay timers sharing only clock and reset; each channel
// takes its own CNT_W-bit slice of the packed delay bus.
module multi_delay_timer
    import timer_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       pause,
    input  logic [N_CH-1:0]       periodic,
    input  logic [N_CH*CNT_W-1:0] delay,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       expire,
    output logic [N_CH-1:0]       busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W    (CNT_W),
            .TICK_DIV (TICK_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[i]),
            .pause    (pause[i]),
            .periodic (periodic[i]),
            .delay    (delay[i*CNT_W +: CNT_W]),
            .done     (done[i]),
            .expire   (expire[i]),
            .busy     (busy[i])
        );
    end

endmodule
